multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Control FSM for the multi-cycle RV32I CPU that replaces the single-cycle control unit.
- Sequences one shared ALU and one unified instruction/data memory over IF/ID/EX/MEM/WB states.
- Drives every datapath mux select, register-enable and memory strobe from the latched IR opcode, the ALU branch condition and a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state register and state output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  IR[6:0]; stable from ID until the next IF.
- alu_bcond  input  1  branch condition from the ALU; valid in EX.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- halt_req  input  1  register file reports x17==10; sampled in ECALL.
- pc_write  output  1  PC register load enable.
- pc_source  output  1  PC input select: 0=ALU result, 1=ALUOut register.
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- mdr_write  output  1  MDR load enable.
- reg_write  output  1  register file write enable.
- wb_src  output  2  rd data select: 0=ALU result, 1=ALUOut, 2=MDR.
- alu_src_a  output  1  ALU operand A: 0=PC, 1=A register.
- alu_src_b  output  2  ALU operand B: 0=B register, 1=constant 4, 2=immediate.
- alu_mode  output  2  ALU control mode: 0=ADD, 1=funct-decoded, 2=branch compare.
- is_ecall  output  1  ECALL state indicator.
- retire  output  1  one-cycle pulse on the cycle the PC is written.
- is_halted  output  1  high in HALT.
- state  output  STATE_W  current state.

Behaviour:
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, JUMP=5, PC4=6, ECALL=7, HALT=8.
- Any output not listed for a state is 0.
- Reset: while reset is high at a rising edge, next state is IF. All outputs are forced to 0 combinationally during any cycle reset is high, and state reads 0. Reset in any state, including mid-MEM, abandons the instruction; no PC or register write occurs in that cycle.
- IF: i_or_d=0, mem_read=1, held until mem_ready. When mem_ready=1: ir_write=1, next state ID; otherwise stay in IF.
- ID: alu_src_a=0, alu_src_b=2, alu_mode=0, so ALUOut <= PC+imm. Next state by opcode:
  - 0110011 and 0010011 -> EX.
  - 0000011 (load) and 0100011 (store) -> EX.
  - 1100011 (branch) -> EX.
  - 1100111 (JALR) -> EX.
  - 1101111 (JAL) -> JUMP.
  - 1110011 -> ECALL.
  - Any other opcode -> PC4 (executes as a NOP).
- EX, R-type: alu_src_a=1, alu_src_b=0, alu_mode=1; next state WB.
- EX, I-arith: alu_src_a=1, alu_src_b=2, alu_mode=1; next state WB.
- EX, load/store: alu_src_a=1, alu_src_b=2, alu_mode=0; next state MEM.
- EX, JALR: alu_src_a=1, alu_src_b=2, alu_mode=0, so ALUOut <= rs1+imm; next state JUMP.
- EX, branch: alu_src_a=1, alu_src_b=0, alu_mode=2.
  - alu_bcond=1: pc_write=1, pc_source=1, retire=1, next state IF.
  - alu_bcond=0: next state PC4.
  - pc_write is a Mealy output on alu_bcond.
- MEM: i_or_d=1; mem_read=1 for load, mem_write=1 for store, both held stable until mem_ready.
  - On mem_ready with a load: mdr_write=1, next state WB.
  - On mem_ready with a store: next state PC4.
  - Strobes deassert the cycle after the mem_ready cycle.
- WB: reg_write=1; wb_src=2 for load, 1 otherwise. In the same cycle: alu_src_a=0, alu_src_b=1, alu_mode=0, pc_write=1, pc_source=0, retire=1. Next state IF.
- JUMP: alu_src_a=0, alu_src_b=1, alu_mode=0, reg_write=1, wb_src=0 (rd <= PC+4), pc_write=1, pc_source=1 (PC <= ALUOut), retire=1. Next state IF.
- PC4: alu_src_a=0, alu_src_b=1, alu_mode=0, pc_write=1, pc_source=0, retire=1. Next state IF.
- ECALL: is_ecall=1. If halt_req=1, next state HALT. Otherwise next state PC4.
- HALT: is_halted=1; all strobes and write enables 0; remains in HALT until reset.
- mem_ready is ignored outside IF and MEM. A mem_ready held high continuously gives minimum latency.
- Cycle counts with zero-wait memory:
  - R/I-arith: 4.
  - Load: 5.
  - Store: 5.
  - Branch taken: 3.
  - Branch not taken: 4.
  - JAL: 3.
  - JALR: 4.

Test Plan:
- R-type (0110011), mem_ready tied 1 -> states 0,1,2,4,0; reg_write and pc_write both high only in WB; retire pulses once; 4 cycles.
- Load with mem_ready low 2 cycles in IF and 3 cycles in MEM -> mem_read held stable throughout; ir_write and mdr_write each pulse exactly on their mem_ready cycle; WB has wb_src=2; 10 cycles total.
- Branch, alu_bcond=1 -> EX asserts pc_write=1, pc_source=1, then IF. With alu_bcond=0 -> EX pc_write=0, then PC4 with pc_source=0.
- JALR -> states 0,1,2,5; in JUMP reg_write=1, wb_src=0, pc_source=1.
- ECALL: halt_req=0 -> PC4 then IF. halt_req=1 -> HALT with is_halted=1, holding 20+ cycles with all strobes 0 until reset.
- Reset asserted during MEM of a store while mem_ready=1 -> no PC write; all outputs 0 that cycle; state IF next with mem_read=1. Unknown opcode 0000000 -> 1,6,0 with no reg_write.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control FSM for the multi-cycle RV32I CPU. It sequences one shared ALU
//   and one unified instruction/data memory through the states
//   IF/ID/EX/MEM/WB/JUMP/PC4/ECALL/HALT.
//
// Ports
//   clk        : clock; all state updates happen on the rising edge
//   reset      : synchronous, active-high; forces every output to 0 in the
//                same cycle
//   opcode     : IR[6:0]; stable from ID until the next IF
//   alu_bcond  : branch condition from the ALU, valid in EX
//   mem_ready  : memory completes the current read/write this cycle
//   halt_req   : register file reports x17==10; sampled in ECALL
//   pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write,
//   reg_write, wb_src, alu_src_a, alu_src_b, alu_mode : datapath controls
//   is_ecall   : high in ECALL
//   retire     : one-cycle pulse on the cycle the PC is written
//   is_halted  : high in HALT
//   state      : current state encoding (reads 0 while reset is high)
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               alu_bcond,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic               pc_write,
  output logic               pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mdr_write,
  output logic               reg_write,
  output logic [1:0]         wb_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_mode,
  output logic               is_ecall,
  output logic               retire,
  output logic               is_halted,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_IF    = STATE_W'(0),
    S_ID    = STATE_W'(1),
    S_EX    = STATE_W'(2),
    S_MEM   = STATE_W'(3),
    S_WB    = STATE_W'(4),
    S_JUMP  = STATE_W'(5),
    S_PC4   = STATE_W'(6),
    S_ECALL = STATE_W'(7),
    S_HALT  = STATE_W'(8)
  } state_t;

  // Operand / mode encodings used below.
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_FN  = 2'd1;
  localparam logic [1:0] MODE_BR  = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_OUT   = 2'd1;
  localparam logic [1:0] WB_MDR   = 2'd2;

  state_t r_state;
  state_t w_next;

  logic w_is_rtype;
  logic w_is_iarith;
  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jalr;
  logic w_is_jal;
  logic w_is_system;

  assign w_is_rtype  = (opcode == 7'b0110011);
  assign w_is_iarith = (opcode == 7'b0010011);
  assign w_is_load   = (opcode == 7'b0000011);
  assign w_is_store  = (opcode == 7'b0100011);
  assign w_is_branch = (opcode == 7'b1100011);
  assign w_is_jalr   = (opcode == 7'b1100111);
  assign w_is_jal    = (opcode == 7'b1101111);
  assign w_is_system = (opcode == 7'b1110011);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    pc_write  = 1'b0;
    pc_source = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    reg_write = 1'b0;
    wb_src    = WB_ALU;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REG;
    alu_mode  = MODE_ADD;
    is_ecall  = 1'b0;
    retire    = 1'b0;
    is_halted = 1'b0;
    state     = r_state;

    case (r_state)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          w_next   = S_ID;
        end
      end

      S_ID: begin
        // ALUOut <= PC + imm, used later as branch/JAL target.
        alu_src_b = SRCB_IMM;
        if (w_is_rtype || w_is_iarith || w_is_load || w_is_store ||
            w_is_branch || w_is_jalr) begin
          w_next = S_EX;
        end else if (w_is_jal) begin
          w_next = S_JUMP;
        end else if (w_is_system) begin
          w_next = S_ECALL;
        end else begin
          w_next = S_PC4;
        end
      end

      S_EX: begin
        alu_src_a = 1'b1;
        if (w_is_rtype) begin
          alu_src_b = SRCB_REG;
          alu_mode  = MODE_FN;
          w_next    = S_WB;
        end else if (w_is_iarith) begin
          alu_src_b = SRCB_IMM;
          alu_mode  = MODE_FN;
          w_next    = S_WB;
        end else if (w_is_load || w_is_store) begin
          alu_src_b = SRCB_IMM;
          w_next    = S_MEM;
        end else if (w_is_jalr) begin
          alu_src_b = SRCB_IMM;
          w_next    = S_JUMP;
        end else if (w_is_branch) begin
          alu_src_b = SRCB_REG;
          alu_mode  = MODE_BR;
          // Taken branch retires here straight from ALUOut (PC+imm from ID).
          if (alu_bcond) begin
            pc_write  = 1'b1;
            pc_source = 1'b1;
            retire    = 1'b1;
            w_next    = S_IF;
          end else begin
            w_next    = S_PC4;
          end
        end else begin
          w_next = S_PC4;
        end
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = w_is_load;
        mem_write = w_is_store;
        if (mem_ready) begin
          if (w_is_load) begin
            mdr_write = 1'b1;
            w_next    = S_WB;
          end else begin
            w_next    = S_PC4;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_src    = w_is_load ? WB_MDR : WB_OUT;
        alu_src_b = SRCB_4;
        pc_write  = 1'b1;
        retire    = 1'b1;
        w_next    = S_IF;
      end

      S_JUMP: begin
        alu_src_b = SRCB_4;
        reg_write = 1'b1;
        wb_src    = WB_ALU;
        pc_write  = 1'b1;
        pc_source = 1'b1;
        retire    = 1'b1;
        w_next    = S_IF;
      end

      S_PC4: begin
        alu_src_b = SRCB_4;
        pc_write  = 1'b1;
        retire    = 1'b1;
        w_next    = S_IF;
      end

      S_ECALL: begin
        is_ecall = 1'b1;
        w_next   = halt_req ? S_HALT : S_PC4;
      end

      S_HALT: begin
        is_halted = 1'b1;
      end

      default: begin
        w_next = S_IF;
      end
    endcase

    // Reset abandons the current instruction: every output is forced low
    // in the same cycle so no PC/register/memory write can slip through.
    if (reset) begin
      w_next    = S_IF;
      pc_write  = 1'b0;
      pc_source = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      reg_write = 1'b0;
      wb_src    = WB_ALU;
      alu_src_a = 1'b0;
      alu_src_b = SRCB_REG;
      alu_mode  = MODE_ADD;
      is_ecall  = 1'b0;
      retire    = 1'b0;
      is_halted = 1'b0;
      state     = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Each step drives the inputs for
// one cycle and pushes the full expected output vector onto a scoreboard;
// the vector is popped and compared mid-cycle on the falling edge.
module tb_multicycle_control_fsm;

  localparam int STATE_W = 4;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       mdrw;
    logic       rw;
    logic [1:0] wb;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] am;
    logic       ec;
    logic       ret;
    logic       hl;
  } outs_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_UNK  = 7'b0000000;

  logic               clk;
  logic               reset;
  logic [6:0]         opcode;
  logic               alu_bcond;
  logic               mem_ready;
  logic               halt_req;
  logic               pc_write;
  logic               pc_source;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mdr_write;
  logic               reg_write;
  logic [1:0]         wb_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_mode;
  logic               is_ecall;
  logic               retire;
  logic               is_halted;
  logic [STATE_W-1:0] state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  outs_t exp_q[$];
  string tag_q[$];

  multicycle_control_fsm #(.STATE_W(STATE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .alu_bcond (alu_bcond),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .pc_write  (pc_write),
    .pc_source (pc_source),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .mdr_write (mdr_write),
    .reg_write (reg_write),
    .wb_src    (wb_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_mode  (alu_mode),
    .is_ecall  (is_ecall),
    .retire    (retire),
    .is_halted (is_halted),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector builders, one per state, straight from the state tables.
  function automatic outs_t e_if(input logic rdy);
    outs_t e = '0;
    e.st = 4'd0; e.mr = 1'b1; e.irw = rdy;
    return e;
  endfunction

  function automatic outs_t e_id();
    outs_t e = '0;
    e.st = 4'd1; e.asb = 2'd2;
    return e;
  endfunction

  function automatic outs_t e_ex(input logic [1:0] asb, input logic [1:0] am,
                                 input logic taken);
    outs_t e = '0;
    e.st = 4'd2; e.asa = 1'b1; e.asb = asb; e.am = am;
    e.pcw = taken; e.pcs = taken; e.ret = taken;
    return e;
  endfunction

  function automatic outs_t e_mem(input logic ld, input logic rdy);
    outs_t e = '0;
    e.st = 4'd3; e.iord = 1'b1; e.mr = ld; e.mw = ~ld; e.mdrw = ld & rdy;
    return e;
  endfunction

  function automatic outs_t e_wb(input logic ld);
    outs_t e = '0;
    e.st = 4'd4; e.rw = 1'b1; e.wb = ld ? 2'd2 : 2'd1; e.asb = 2'd1;
    e.pcw = 1'b1; e.ret = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_jump();
    outs_t e = '0;
    e.st = 4'd5; e.asb = 2'd1; e.rw = 1'b1; e.pcw = 1'b1; e.pcs = 1'b1;
    e.ret = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_pc4();
    outs_t e = '0;
    e.st = 4'd6; e.asb = 2'd1; e.pcw = 1'b1; e.ret = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_ecall();
    outs_t e = '0;
    e.st = 4'd7; e.ec = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_halt();
    outs_t e = '0;
    e.st = 4'd8; e.hl = 1'b1;
    return e;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.st = state; o.pcw = pc_write; o.pcs = pc_source; o.iord = i_or_d;
    o.mr = mem_read; o.mw = mem_write; o.irw = ir_write; o.mdrw = mdr_write;
    o.rw = reg_write; o.wb = wb_src; o.asa = alu_src_a; o.asb = alu_src_b;
    o.am = alu_mode; o.ec = is_ecall; o.ret = retire; o.hl = is_halted;
    return o;
  endfunction

  // One clock cycle: drive, push expectation, compare on the falling edge,
  // then advance past the next rising edge.
  task automatic step(input logic [6:0] op, input logic rdy, input logic bc,
                      input logic hr, input logic rst, input outs_t exp,
                      input string tag);
    outs_t got;
    outs_t want;
    string t;
    opcode    = op;
    mem_ready = rdy;
    alu_bcond = bc;
    halt_req  = hr;
    reset     = rst;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    got  = observed();
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = OP_UNK; alu_bcond = 1'b0; mem_ready = 1'b0;
    halt_req = 1'b0;

    step(OP_R, 1, 0, 0, 1, '0, "reset0");
    step(OP_R, 1, 0, 0, 1, '0, "reset1");

    // R-type, zero-wait: 0,1,2,4 then IF again
    step(OP_R, 1, 0, 0, 0, e_if(1),              "r_if");
    step(OP_R, 1, 0, 0, 0, e_id(),               "r_id");
    step(OP_R, 1, 0, 0, 0, e_ex(2'd0, 2'd1, 0),  "r_ex");
    step(OP_R, 1, 0, 0, 0, e_wb(0),              "r_wb");

    // I-arith
    step(OP_I, 1, 0, 0, 0, e_if(1),              "i_if");
    step(OP_I, 1, 0, 0, 0, e_id(),               "i_id");
    step(OP_I, 1, 0, 0, 0, e_ex(2'd2, 2'd1, 0),  "i_ex");
    step(OP_I, 1, 0, 0, 0, e_wb(0),              "i_wb");

    // Load with 2 IF waits and 3 MEM waits: 10 cycles
    step(OP_LD, 0, 0, 0, 0, e_if(0),             "ld_if_w0");
    step(OP_LD, 0, 0, 0, 0, e_if(0),             "ld_if_w1");
    step(OP_LD, 1, 0, 0, 0, e_if(1),             "ld_if_rdy");
    step(OP_LD, 1, 0, 0, 0, e_id(),              "ld_id");
    step(OP_LD, 1, 0, 0, 0, e_ex(2'd2, 2'd0, 0), "ld_ex");
    step(OP_LD, 0, 0, 0, 0, e_mem(1, 0),         "ld_mem_w0");
    step(OP_LD, 0, 0, 0, 0, e_mem(1, 0),         "ld_mem_w1");
    step(OP_LD, 0, 0, 0, 0, e_mem(1, 0),         "ld_mem_w2");
    step(OP_LD, 1, 0, 0, 0, e_mem(1, 1),         "ld_mem_rdy");
    step(OP_LD, 1, 0, 0, 0, e_wb(1),             "ld_wb");

    // Store, zero-wait: 5 cycles
    step(OP_ST, 1, 0, 0, 0, e_if(1),             "st_if");
    step(OP_ST, 1, 0, 0, 0, e_id(),              "st_id");
    step(OP_ST, 1, 0, 0, 0, e_ex(2'd2, 2'd0, 0), "st_ex");
    step(OP_ST, 1, 0, 0, 0, e_mem(0, 1),         "st_mem");
    step(OP_ST, 1, 0, 0, 0, e_pc4(),             "st_pc4");

    // Branch taken: 3 cycles
    step(OP_BR, 1, 1, 0, 0, e_if(1),             "bt_if");
    step(OP_BR, 1, 1, 0, 0, e_id(),              "bt_id");
    step(OP_BR, 1, 1, 0, 0, e_ex(2'd0, 2'd2, 1), "bt_ex");

    // Branch not taken: 4 cycles
    step(OP_BR, 1, 0, 0, 0, e_if(1),             "bn_if");
    step(OP_BR, 1, 0, 0, 0, e_id(),              "bn_id");
    step(OP_BR, 1, 0, 0, 0, e_ex(2'd0, 2'd2, 0), "bn_ex");
    step(OP_BR, 1, 0, 0, 0, e_pc4(),             "bn_pc4");

    // JAL: 3 cycles
    step(OP_JAL, 1, 0, 0, 0, e_if(1),            "jal_if");
    step(OP_JAL, 1, 0, 0, 0, e_id(),             "jal_id");
    step(OP_JAL, 1, 0, 0, 0, e_jump(),           "jal_jump");

    // JALR: 4 cycles
    step(OP_JALR, 1, 0, 0, 0, e_if(1),             "jalr_if");
    step(OP_JALR, 1, 0, 0, 0, e_id(),              "jalr_id");
    step(OP_JALR, 1, 0, 0, 0, e_ex(2'd2, 2'd0, 0), "jalr_ex");
    step(OP_JALR, 1, 0, 0, 0, e_jump(),            "jalr_jump");

    // ECALL without halt
    step(OP_SYS, 1, 0, 0, 0, e_if(1),            "ec_if");
    step(OP_SYS, 1, 0, 0, 0, e_id(),             "ec_id");
    step(OP_SYS, 1, 0, 0, 0, e_ecall(),          "ec_ecall");
    step(OP_SYS, 1, 0, 0, 0, e_pc4(),            "ec_pc4");

    // Unknown opcode executes as NOP
    step(OP_UNK, 1, 0, 0, 0, e_if(1),            "unk_if");
    step(OP_UNK, 1, 0, 0, 0, e_id(),             "unk_id");
    step(OP_UNK, 1, 0, 0, 0, e_pc4(),            "unk_pc4");

    // Reset during MEM of a store with mem_ready high
    step(OP_ST, 1, 0, 0, 0, e_if(1),             "rs_if");
    step(OP_ST, 1, 0, 0, 0, e_id(),              "rs_id");
    step(OP_ST, 1, 0, 0, 0, e_ex(2'd2, 2'd0, 0), "rs_ex");
    step(OP_ST, 1, 0, 0, 1, '0,                  "rs_mem_reset");
    step(OP_ST, 0, 0, 0, 0, e_if(0),             "rs_after_if");
    step(OP_ST, 1, 0, 0, 0, e_if(1),             "rs_after_if_rdy");
    step(OP_ST, 1, 0, 0, 0, e_id(),              "rs_after_id");
    step(OP_ST, 1, 0, 0, 0, e_ex(2'd2, 2'd0, 0), "rs_after_ex");
    step(OP_ST, 1, 0, 0, 0, e_mem(0, 1),         "rs_after_mem");
    step(OP_ST, 1, 0, 0, 0, e_pc4(),             "rs_after_pc4");

    // ECALL with halt: HALT holds while inputs wiggle
    step(OP_SYS, 1, 0, 1, 0, e_if(1),            "h_if");
    step(OP_SYS, 1, 0, 1, 0, e_id(),             "h_id");
    step(OP_SYS, 1, 0, 1, 0, e_ecall(),          "h_ecall");
    for (int i = 0; i < 22; i++) begin
      step(OP_R, 1'(i), 1'(i >> 1), 1'(i >> 2), 0, e_halt(), "halt_hold");
    end
    step(OP_R, 1, 0, 0, 1, '0,                   "halt_reset");
    step(OP_R, 1, 0, 0, 0, e_if(1),              "post_halt_if");
    step(OP_R, 1, 0, 0, 0, e_id(),               "post_halt_id");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
